// File: rtl/serial_pkg.sv
// rtl/serial_pkg.sv - shared types and helpers for the serial detector chain front end
//
// Contents:
//   ser_state_t   : serializer FSM state encoding (IDLE, SHIFT, PARITY)
//   SER_WIDTH_MAX : widest word any serializer in the chain may carry
//   parity_even   : even-parity bit of a word (zero-extend narrower words)
package serial_pkg;

  localparam int SER_WIDTH_MAX = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } ser_state_t;

  // XOR of all bits: 1 when the word holds an odd number of ones, so that
  // word plus this bit always carries an even count of ones.
  function automatic logic parity_even(input logic [SER_WIDTH_MAX-1:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/bit_serializer_if.sv
// rtl/bit_serializer_if.sv - word-in / bit-out bundle between a word source and the serializer
//
// Signals:
//   din        : parallel word, MSB sent first
//   din_valid  : din holds a word to send
//   din_ready  : serializer accepts a word this cycle
//   stall      : freeze serial output and state
//   sout       : serial data bit
//   sout_valid : sout carries a word or parity bit
//   busy       : a word is in flight
// Modports:
//   master : word source / bench side
//   slave  : serializer side
interface bit_serializer_if #(
  parameter int WIDTH = 8
) ();

  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             stall;
  logic             sout;
  logic             sout_valid;
  logic             busy;

  modport master (
    output din,
    output din_valid,
    output stall,
    input  din_ready,
    input  sout,
    input  sout_valid,
    input  busy
  );

  modport slave (
    input  din,
    input  din_valid,
    input  stall,
    output din_ready,
    output sout,
    output sout_valid,
    output busy
  );

endinterface

// File: rtl/bit_serializer.sv
// rtl/bit_serializer.sv - parallel-to-serial front end, MSB first, optional even parity
//
// Parameters:
//   WIDTH : word width in bits, 2..32
// Ports:
//   clk   : clock, all state on rising edge
//   reset : asynchronous, active-high reset
//   ifc   : bit_serializer_if.slave (din/din_valid/din_ready, stall,
//           sout/sout_valid, busy)
// Configuration macro:
//   BIT_SERIALIZER_PARITY_EN : append an even-parity bit after data bit 0
//
// sout feeds the serial input of the downstream 1101 detector; idle cycles
// present sout = 0 which cannot start a false match.
import serial_pkg::*;

module bit_serializer #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  bit_serializer_if.slave    ifc
);

  localparam int              CW      = $clog2(WIDTH);
  localparam logic [CW-1:0]   CNT_TOP = CW'(WIDTH - 1);
  localparam logic [CW-1:0]   CNT_ONE = CW'(1);

  ser_state_t       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] shreg;
  logic             last_bit;
  logic             accept;

`ifdef BIT_SERIALIZER_PARITY_EN
  // Parity is latched with the word so it never depends on the shifted copy.
  logic             parity_q;

  assign last_bit = (state == PARITY);
`else
  assign last_bit = (state == SHIFT) && (cnt == '0);
`endif

  // Ready in the final-bit cycle lets the next word follow with no gap bit.
  assign ifc.din_ready = (state == IDLE) || (last_bit && !ifc.stall);
  assign accept        = ifc.din_valid && ifc.din_ready;
  assign ifc.busy      = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      cnt            <= '0;
      shreg          <= '0;
      ifc.sout       <= 1'b0;
      ifc.sout_valid <= 1'b0;
`ifdef BIT_SERIALIZER_PARITY_EN
      parity_q       <= 1'b0;
`endif
    end else if (accept) begin
      // Acceptance only happens in IDLE or in an unstalled final-bit cycle,
      // so loading here covers both the fresh start and back-to-back cases.
      // An IDLE handshake is taken even under stall; the MSB then holds.
      state          <= SHIFT;
      cnt            <= CNT_TOP;
      shreg          <= ifc.din;
      ifc.sout       <= ifc.din[WIDTH-1];
      ifc.sout_valid <= 1'b1;
`ifdef BIT_SERIALIZER_PARITY_EN
      parity_q       <= parity_even(SER_WIDTH_MAX'(ifc.din));
`endif
    end else begin
      case (state)
        IDLE: begin
          ifc.sout       <= 1'b0;
          ifc.sout_valid <= 1'b0;
        end

        SHIFT: begin
          if (!ifc.stall) begin
            if (cnt != '0) begin
              cnt      <= cnt - CNT_ONE;
              shreg    <= {shreg[WIDTH-2:0], 1'b0};
              ifc.sout <= shreg[WIDTH-2];
            end else begin
`ifdef BIT_SERIALIZER_PARITY_EN
              state          <= PARITY;
              ifc.sout       <= parity_q;
              ifc.sout_valid <= 1'b1;
`else
              state          <= IDLE;
              cnt            <= '0;
              ifc.sout       <= 1'b0;
              ifc.sout_valid <= 1'b0;
`endif
            end
          end
        end

        PARITY: begin
          if (!ifc.stall) begin
            state          <= IDLE;
            cnt            <= '0;
            ifc.sout       <= 1'b0;
            ifc.sout_valid <= 1'b0;
          end
        end

        default: begin
          state          <= IDLE;
          cnt            <= '0;
          ifc.sout       <= 1'b0;
          ifc.sout_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bit_serializer.sv
// tb/tb_bit_serializer.sv - self-checking bench for bit_serializer against a bit-queue model
module tb_bit_serializer;

  localparam int WIDTH = 8;
`ifdef BIT_SERIALIZER_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int WBITS = WIDTH + P;

  logic clk = 1'b0;
  logic reset = 1'b1;

  bit_serializer_if #(.WIDTH(WIDTH)) ifc ();

  bit_serializer #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .ifc   (ifc)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: bits still to appear on sout for the word in flight; front is the
  // bit currently on the wire. Empty means idle.
  bit         cur[$];
  int         acc_cnt = 0;
  logic [3:0] obs;   // {sout_valid, sout, busy, din_ready}
  logic [3:0] expv;
  logic [3:0] hist = 4'b0000;
  int         pulses = 0;
  int         pulse_at = -1;
  int         bitno = 0;

  function automatic void load_word(input logic [WIDTH-1:0] w);
    cur.delete();
    for (int i = WIDTH - 1; i >= 0; i--) cur.push_back(w[i]);
    if (P == 1) cur.push_back(^w);
  endfunction

  // One clock: drive inputs at negedge, sample, predict, advance the model.
  task automatic drive(input logic v, input logic [WIDTH-1:0] d, input logic s);
    logic rdy;
    @(negedge clk);
    ifc.din_valid = v;
    ifc.din       = d;
    ifc.stall     = s;
    #1;
    rdy  = (cur.size() == 0) || (cur.size() == 1 && !s);
    expv = {cur.size() != 0, (cur.size() != 0) ? cur[0] : 1'b0, cur.size() != 0, rdy};
    obs  = {ifc.sout_valid, ifc.sout, ifc.busy, ifc.din_ready};
    // Reference 1101 overlapping Mealy detector on the observed serial line.
    hist = {hist[2:0], ifc.sout};
    if (hist == 4'b1101) begin
      pulses++;
      pulse_at = bitno;
    end
    if (ifc.sout_valid) bitno++;
    if (cur.size() != 0 && !s) void'(cur.pop_front());
    if (v && rdy) begin
      load_word(d);
      acc_cnt++;
    end
  endtask

  task automatic test_reset();
    ifc.din_valid = 1'b0;
    ifc.din       = '0;
    ifc.stall     = 1'b0;
    reset         = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    if ({ifc.sout_valid, ifc.sout, ifc.busy} !== 3'b000) begin
      bad++;
      $display("FAIL reset_outputs got=%b want=000", {ifc.sout_valid, ifc.sout, ifc.busy});
    end
    total++;
    reset = 1'b0;
    #1;
    if (ifc.din_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_ready got=%b want=1", ifc.din_ready);
    end
    total++;
  endtask

  task automatic test_d0();
    bit         got[$];
    logic [8:0] want;
    want     = {8'hD0, 1'b1};
    hist     = 4'b0000;
    pulses   = 0;
    pulse_at = -1;
    bitno    = 0;
    drive(1'b1, 8'hD0, 1'b0);
    for (int c = 0; c < WBITS + 3; c++) begin
      if (c != 0) drive(1'b0, WIDTH'($urandom), 1'b0);
      if (obs !== expv) begin
        bad++;
        $display("FAIL d0_cycle c=%0d got=%b want=%b", c, obs, expv);
      end
      total++;
      if (obs[3]) got.push_back(obs[2]);
    end
    if (got.size() != WBITS) begin
      bad++;
      $display("FAIL d0_length got=%0d want=%0d", got.size(), WBITS);
    end
    total++;
    for (int i = 0; i < WBITS && i < got.size(); i++) begin
      if (got[i] !== want[8-i]) begin
        bad++;
        $display("FAIL d0_bit i=%0d got=%b want=%b", i, got[i], want[8-i]);
      end
      total++;
    end
    if (pulses != 1 || pulse_at != 3) begin
      bad++;
      $display("FAIL d0_detector pulses=%0d at=%0d want 1 at 3", pulses, pulse_at);
    end
    total++;
  endtask

  task automatic test_back_to_back();
    int start;
    int run;
    int best;
    int guard;
    start = acc_cnt;
    run   = 0;
    best  = 0;
    guard = 0;
    drive(1'b1, 8'hDD, 1'b0);
    while (acc_cnt < start + 2 && guard < 3 * WBITS) begin
      drive(1'b1, 8'h0D, 1'b0);
      guard++;
      if (obs !== expv) begin
        bad++;
        $display("FAIL b2b_cycle g=%0d got=%b want=%b", guard, obs, expv);
      end
      total++;
      if (obs[3]) run++; else run = 0;
      if (run > best) best = run;
      if (run == WBITS) begin
        if (obs[0] !== 1'b1) begin
          bad++;
          $display("FAIL b2b_ready_last got=%b want=1", obs[0]);
        end
        total++;
      end
    end
    if (acc_cnt < start + 2) begin
      bad++;
      $display("FAIL b2b_timeout accepted=%0d want=2", acc_cnt - start);
    end
    total++;
    for (int c = 0; c < WBITS + 2; c++) begin
      drive(1'b0, WIDTH'($urandom), 1'b0);
      if (obs !== expv) begin
        bad++;
        $display("FAIL b2b_drain c=%0d got=%b want=%b", c, obs, expv);
      end
      total++;
      if (obs[3]) run++; else run = 0;
      if (run > best) best = run;
    end
    if (best != 2 * WBITS) begin
      bad++;
      $display("FAIL b2b_contiguous got=%0d want=%0d", best, 2 * WBITS);
    end
    total++;
  endtask

  task automatic test_stall();
    int nvalid;
    logic s;
    nvalid = 0;
    drive(1'b1, 8'hA5, 1'b0);
    for (int c = 0; c < WBITS + 6; c++) begin
      s = (c >= 1 && c <= 3);
      drive(1'b0, WIDTH'($urandom), s);
      if (obs !== expv) begin
        bad++;
        $display("FAIL stall_cycle c=%0d got=%b want=%b", c, obs, expv);
      end
      total++;
      if (s && obs[0] !== 1'b0) begin
        bad++;
        $display("FAIL stall_ready c=%0d got=%b want=0", c, obs[0]);
      end
      if (s) total++;
      if (obs[3]) nvalid++;
    end
    if (nvalid != WBITS + 3) begin
      bad++;
      $display("FAIL stall_valid_count got=%0d want=%0d", nvalid, WBITS + 3);
    end
    total++;
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 8'hFF, 1'b0);
    repeat (3) drive(1'b0, 8'h00, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    if ({ifc.sout_valid, ifc.sout, ifc.busy} !== 3'b000) begin
      bad++;
      $display("FAIL midreset_outputs got=%b want=000", {ifc.sout_valid, ifc.sout, ifc.busy});
    end
    total++;
    cur.delete();
    @(posedge clk);
    #2;
    reset = 1'b0;
    drive(1'b1, 8'h81, 1'b0);
    for (int c = 0; c < WBITS + 3; c++) begin
      if (c != 0) drive(1'b0, WIDTH'($urandom), 1'b0);
      if (obs !== expv) begin
        bad++;
        $display("FAIL midreset_restart c=%0d got=%b want=%b", c, obs, expv);
      end
      total++;
    end
  endtask

  task automatic test_idle();
    for (int c = 0; c < 20; c++) begin
      drive(1'b0, WIDTH'($urandom), 1'b0);
      if (obs !== 4'b0001 || obs !== expv) begin
        bad++;
        $display("FAIL idle_cycle c=%0d got=%b want=0001", c, obs);
      end
      total++;
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      drive($urandom_range(0, 9) < 7, WIDTH'($urandom), $urandom_range(0, 3) == 0);
      if (obs !== expv) begin
        bad++;
        $display("FAIL random_cycle c=%0d got=%b want=%b", c, obs, expv);
      end
      total++;
    end
    for (int c = 0; c < 3 * WBITS; c++) begin
      drive(1'b0, WIDTH'($urandom), 1'b0);
      if (obs !== expv) begin
        bad++;
        $display("FAIL random_drain c=%0d got=%b want=%b", c, obs, expv);
      end
      total++;
    end
  endtask

  initial begin
    test_reset();
    test_d0();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    test_idle();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
